// File: rtl/fixp_add_scheduler.sv
// Round-robin shared-adder scheduler: one CHUNK_WIDTH adder serves NUM_REQ requesters,
// sequencing each TOTAL_WIDTH add LSB chunk first with a registered carry.
//   state | meaning
//   IDLE  | arbitrate, accept one request
//   ADD   | one chunk add per cycle, NUM_CHUNKS cycles
//   RESP  | hold result until rsp_ready
module fixp_add_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int TOTAL_WIDTH = 512,
    parameter int CHUNK_WIDTH = 128,
    localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           axis_aclk,
    input  logic                           axis_rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*TOTAL_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*TOTAL_WIDTH-1:0] req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [TOTAL_WIDTH:0]           rsp_sum,
    output logic [IDW-1:0]                 rsp_id,
    output logic                           busy
);
    localparam int NUM_CHUNKS = TOTAL_WIDTH / CHUNK_WIDTH;
    localparam int CIW        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [TOTAL_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [TOTAL_WIDTH:0]   sum_q, sum_d;
    logic                   carry_q, carry_d;
    logic [CIW-1:0]         chunk_q, chunk_d;
    logic [IDW-1:0]         id_q, id_d;
    logic [IDW-1:0]         last_grant_q, last_grant_d;
    logic                   valid_q, valid_d;

    logic [IDW:0]           cand;
    logic                   grant_vld;
    logic [IDW-1:0]         grant_idx;
    logic [NUM_REQ-1:0]     grant_oh;
    logic [TOTAL_WIDTH-1:0] a_sel, b_sel;
    logic                   accept;
    logic [CHUNK_WIDTH-1:0] chunk_sum;
    logic                   chunk_cout;
    logic [TOTAL_WIDTH+CHUNK_WIDTH-1:0] sum_shift;

    // Search starts one past the last grant so the previous winner has lowest priority.
    always_comb begin
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ))
                cand = cand - (IDW+1)'(NUM_REQ);
            if (!grant_vld && req_valid[cand[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        a_sel    = '0;
        b_sel    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && grant_idx == IDW'(i)) begin
                grant_oh[i] = 1'b1;
                a_sel       = req_a[i*TOTAL_WIDTH +: TOTAL_WIDTH];
                b_sel       = req_b[i*TOTAL_WIDTH +: TOTAL_WIDTH];
            end
        end
    end

    assign req_ready = (state_q == IDLE && !axis_rst) ? grant_oh : '0;
    assign accept    = |(req_valid & req_ready);

    // The single shared adder; operands are shifted down so the active chunk is always the LSBs.
    assign {chunk_cout, chunk_sum} = {1'b0, a_q[CHUNK_WIDTH-1:0]}
                                   + {1'b0, b_q[CHUNK_WIDTH-1:0]}
                                   + {{CHUNK_WIDTH{1'b0}}, carry_q};
    assign sum_shift = {chunk_sum, sum_q[TOTAL_WIDTH-1:0]};

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        chunk_d      = chunk_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        valid_d      = valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d          = a_sel;
                    b_d          = b_sel;
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    chunk_d      = '0;
                    carry_d      = 1'b0;
                    state_d      = ADD;
                end
            end
            ADD: begin
                a_d                     = a_q >> CHUNK_WIDTH;
                b_d                     = b_q >> CHUNK_WIDTH;
                sum_d[TOTAL_WIDTH-1:0]  = sum_shift[TOTAL_WIDTH+CHUNK_WIDTH-1:CHUNK_WIDTH];
                carry_d                 = chunk_cout;
                chunk_d                 = chunk_q + CIW'(1);
                if (chunk_q == CIW'(NUM_CHUNKS-1)) begin
                    sum_d[TOTAL_WIDTH] = chunk_cout;
                    chunk_d            = '0;
                    valid_d            = 1'b1;
                    state_d            = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            chunk_q      <= '0;
            id_q         <= '0;
            last_grant_q <= IDW'(NUM_REQ-1);
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            chunk_q      <= chunk_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            valid_q      <= valid_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fixp_add_scheduler.sv
// Bench for fixp_add_scheduler: directed scenarios with literal expectations plus a
// transaction-level model (RR pick, plain a+b, fixed latency) checked every cycle.
module tb_fixp_add_scheduler;
    localparam int NR = 4;
    localparam int TW = 512;
    localparam int LAT = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_ready;
    logic [NR*TW-1:0]   req_a = '0;
    logic [NR*TW-1:0]   req_b = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [TW:0]        rsp_sum;
    logic [1:0]         rsp_id;
    logic               busy;

    always #5 clk = ~clk;

    fixp_add_scheduler #(.NUM_REQ(NR), .TOTAL_WIDTH(TW), .CHUNK_WIDTH(128)) dut (
        .axis_aclk(clk), .axis_rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [TW:0] act, input logic [TW:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
        int i;
        for (int k = 1; k <= NR; k++) begin
            i = (ptr + k) % NR;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Transaction model: an accepted op answers LAT cycles later with a+b and waits for rsp_ready.
    bit          m_busy = 1'b0;
    int          m_acc  = 0;
    int          m_id   = 0;
    int          m_ptr  = NR-1;
    logic [TW:0] m_sum  = '0;

    always @(negedge clk) begin
        int g;
        logic [NR-1:0] exp_rdy;
        cyc++;
        if (rst) begin
            check("rst_req_ready", TW'(req_ready), '0);
            m_busy = 1'b0;
            m_ptr  = NR-1;
        end else if (!m_busy) begin
            g       = rr_pick(req_valid, m_ptr);
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("idle_req_ready", TW'(req_ready), TW'(exp_rdy));
            check("idle_busy", TW'(busy), '0);
            check("idle_rsp_valid", TW'(rsp_valid), '0);
            if (g >= 0) begin
                m_busy = 1'b1;
                m_acc  = cyc;
                m_id   = g;
                m_ptr  = g;
                m_sum  = {1'b0, req_a[g*TW +: TW]} + {1'b0, req_b[g*TW +: TW]};
            end
        end else begin
            check("busy_req_ready", TW'(req_ready), '0);
            check("busy_flag", TW'(busy), 1);
            if (cyc - m_acc >= LAT) begin
                check("rsp_valid", TW'(rsp_valid), 1);
                check("rsp_sum", rsp_sum, m_sum);
                check("rsp_id", TW'(rsp_id), TW'(m_id));
                if (rsp_ready) m_busy = 1'b0;
            end else begin
                check("add_rsp_valid", TW'(rsp_valid), '0);
            end
        end
    end

    task automatic set_ops(input int i, input logic [TW-1:0] a, input logic [TW-1:0] b);
        req_a[i*TW +: TW] = a;
        req_b[i*TW +: TW] = b;
    endtask

    task automatic issue(input int i, input logic [TW-1:0] a, input logic [TW-1:0] b);
        int n;
        set_ops(i, a, b);
        req_valid[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 40);
        check("grant_seen", TW'(req_ready[i]), 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_grant(output logic [NR-1:0] g);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 40);
        check("grant_seen", TW'(|req_ready), 1);
        g = req_ready;
    endtask

    task automatic wait_rsp(input logic [TW:0] exp_sum, input int exp_id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 40);
        check("latency", TW'(n), TW'(LAT));
        check("lit_sum", rsp_sum, exp_sum);
        check("lit_id", TW'(rsp_id), TW'(exp_id));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW:0]   e;
        logic [NR-1:0] g;
        int            order [5];
        int            prev_cyc;
        int            n;
        order = '{0, 1, 2, 3, 0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: all-ones + 1 carries out of every chunk
        issue(0, {TW{1'b1}}, TW'(1));
        e = '0; e[512] = 1'b1;
        wait_rsp(e, 0);

        // 2: carry across one chunk boundary, then a no-carry op
        issue(1, TW'({128{1'b1}}), TW'(1));
        e = '0; e[128] = 1'b1;
        wait_rsp(e, 1);
        issue(1, TW'(5), TW'(7));
        wait_rsp(513'hC, 1);

        // 3: fairness with all requesters asserting
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < NR; i++)
            set_ops(i, {16{32'hDEAD_0000 + 32'(i)}}, {16{32'h2152_FFFF + 32'(i)}});
        req_valid = '1;
        prev_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            e = '0; e[order[k]] = 1'b1;
            check("rr_order", TW'(g), e);
            if (k > 0) check("rr_spacing", TW'(cyc - prev_cyc), TW'(6));
            prev_cyc = cyc;
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (8) @(posedge clk);
        #1;

        // 4: pointer at 0, requesters 0 and 2 -> 2 first
        set_ops(0, TW'(100), TW'(23));
        set_ops(2, TW'(1000), TW'(1));
        req_valid = 4'b0101;
        wait_grant(g);
        check("ptr_first", TW'(g), TW'(4'b0100));
        @(posedge clk); #1 req_valid[2] = 1'b0;
        wait_grant(g);
        check("ptr_second", TW'(g), TW'(4'b0001));
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_rsp(513'd123, 0);

        // 5: backpressure in RESP
        rsp_ready = 1'b0;
        issue(1, TW'(64'hFFFF_FFFF_FFFF_FFFF), TW'(1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 40);
        check("bp_latency", TW'(n), TW'(LAT));
        @(posedge clk); #1;
        set_ops(3, TW'(10), TW'(20));
        req_valid[3] = 1'b1;
        e = '0; e[64] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid", TW'(rsp_valid), 1);
            check("bp_sum", rsp_sum, e);
            check("bp_id", TW'(rsp_id), TW'(1));
            check("bp_req_ready", TW'(req_ready), '0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[3] && n < 40);
        check("bp_next_accept", TW'(n), TW'(2));
        @(posedge clk); #1 req_valid[3] = 1'b0;
        wait_rsp(513'd30, 3);

        // 6: reset while chunk 2 is being added
        issue(1, {TW{1'b1}}, {TW{1'b1}});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_ops(0, TW'(7), TW'(8));
        set_ops(3, TW'(1), TW'(1));
        req_valid = 4'b1001;
        wait_grant(g);
        check("post_rst_grant", TW'(g), TW'(4'b0001));
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(513'd15, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fixp_add_scheduler.md
Name: fixp_add_scheduler

Overview:
Shares a single CHUNK_WIDTH-bit fixed-point adder among NUM_REQ requesters that each need TOTAL_WIDTH-bit additions. A round-robin arbiter grants one requester at a time. The block then sequences the wide add as NUM_CHUNKS chunk adds, LSB chunk first, with the carry chained through a register. It sits in the fixp_acc datapath in front of the accumulators and trades adder area for multi-cycle latency.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
TOTAL_WIDTH, 512, operand width in bits
CHUNK_WIDTH, 128, shared adder width; TOTAL_WIDTH must be an integer multiple; NUM_CHUNKS = TOTAL_WIDTH/CHUNK_WIDTH (local)

Ports:
axis_aclk  in  1  clock
axis_rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  NUM_REQ*TOTAL_WIDTH  operand A; requester i occupies slice [i*TOTAL_WIDTH +: TOTAL_WIDTH]
req_b  in  NUM_REQ*TOTAL_WIDTH  operand B; same slicing as req_a
rsp_valid  out  1  result valid
rsp_ready  in  1  downstream accept
rsp_sum  out  TOTAL_WIDTH+1  unsigned sum; MSB is the final carry
rsp_id  out  max(1,$clog2(NUM_REQ))  index of the granted requester
busy  out  1  high whenever state != IDLE

Behaviour:
- Datapath resources: exactly one CHUNK_WIDTH-bit adder with carry-in. No other adder wider than the chunk-index counter.
- Reset (axis_rst=1 at a clock edge):
  - state=IDLE, rsp_valid=0, rsp_sum=0, rsp_id=0, carry=0, chunk_idx=0.
  - RR pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
  - req_ready is forced to 0 while axis_rst is high.
  - Reset mid-operation discards the in-flight op. No response is produced for it.
- States:
  - IDLE: req_ready[g]=1 combinationally, where g is the first i with req_valid[i]=1, searching last_grant+1, last_grant+2, … modulo NUM_REQ. All other req_ready bits are 0. If no req_valid bit is set, req_ready=0.
  - On handshake (req_valid[g] & req_ready[g]): latch req_a/req_b slices of g into operand registers, rsp_id<=g, last_grant<=g, chunk_idx<=0, carry<=0, then go to ADD.
  - ADD: each cycle compute {c_out, s} = a_chunk[chunk_idx] + b_chunk[chunk_idx] + carry. Write s into result slice [chunk_idx*CHUNK_WIDTH +: CHUNK_WIDTH]; carry<=c_out; chunk_idx++.
  - ADD exit: in the cycle with chunk_idx==NUM_CHUNKS-1, write c_out to rsp_sum[TOTAL_WIDTH] and go to RESP. ADD lasts exactly NUM_CHUNKS cycles.
  - RESP: rsp_valid=1. rsp_sum and rsp_id are held stable until rsp_ready=1. On handshake: rsp_valid<=0, go to IDLE. req_ready=0 in ADD and RESP.
- Latency:
  - Request accepted at cycle T gives rsp_valid high at cycle T+NUM_CHUNKS+1 (T+5 at defaults).
  - With rsp_ready held high, sustained throughput is one op per NUM_CHUNKS+2 cycles.
- Requester rule: operands must stay stable while req_valid is high and unaccepted. A requester that drops req_valid before it is granted is simply not granted; the pointer does not move.
- Wrap-around:
  - The sum wraps into TOTAL_WIDTH+1 bits; no saturation.
  - chunk_idx resets to 0 at each new op.
  - The RR pointer wraps from NUM_REQ-1 to 0.
- Simultaneous events:
  - Multiple req_valid bits in IDLE: the RR order decides.
  - Requests arriving during ADD/RESP wait for the next IDLE.
  - rsp_ready high before RESP has no effect.

Test Plan:
1. Single op, req0 only: a=2^512-1, b=1 -> rsp_valid 5 cycles after accept, rsp_sum=2^512 (bit 512 set, others 0), rsp_id=0.
2. Chunk carry chain: req1 a=2^128-1, b=1 -> rsp_sum=2^128, rsp_id=1. Also a=0x5, b=0x7 -> rsp_sum=0xC, bit 512=0.
3. Fairness: all 4 req_valid held high, rsp_ready=1, distinct operands -> grants in order 0,1,2,3,0. Each rsp_id and sum match its operands; one accept every 6 cycles.
4. Pointer semantics: after req0 is granted, req0 and req2 both valid -> req2 granted first, then req0.
5. Backpressure: rsp_ready low for 10 cycles in RESP -> rsp_valid/rsp_sum/rsp_id stable, req_ready stays 0. rsp_ready=1 -> handshake, next accept on the following cycle.
6. Reset mid-ADD (chunk_idx=2) -> no rsp_valid, busy=0 the next cycle. A subsequent request from req0 and req3 together grants req0, and its sum is correct.
